// File: rtl/bolme_istemci_pkg.sv
// Shared definitions for the division client.
// Holds the operation encodings, the FSM state encodings, the data widths
// and small decode helpers used by the client and its operand cache.
package bolme_istemci_pkg;

    localparam int unsigned VeriGen  = 32;
    localparam int unsigned HedefGen = 5;

    typedef enum logic [1:0] {
        IslemDiv  = 2'b00,
        IslemDivu = 2'b01,
        IslemRem  = 2'b10,
        IslemRemu = 2'b11
    } islem_e;

    typedef enum logic [2:0] {
        StBos   = 3'd0,  // idle
        StIstek = 3'd1,  // divider request cycle
        StBekle = 3'd2,  // waiting for the divider
        StIptal = 3'd3,  // flushed, still draining the divider
        StSon   = 3'd4   // result cycle
    } durum_e;

    // Signed operations are DIV and REM.
    function automatic logic isaretli_islem(input logic [1:0] islem);
        return (islem == IslemDiv) || (islem == IslemRem);
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient.
    function automatic logic kalan_islemi(input logic [1:0] islem);
        return (islem == IslemRem) || (islem == IslemRemu);
    endfunction

endpackage

// File: rtl/bolme_istemci_if.sv
// Compare/fill/valid bundle between the division client and its
// one-entry operand cache.
//   kars_*    : operands of the request being considered (client -> cache)
//   eslesme   : stored operands equal kars_* (cache -> client)
//   gecerli   : cache entry holds a result (cache -> client)
//   doldur*   : write operands and divider result into the entry
//   bolum/kalan : stored quotient and remainder (cache -> client)
interface bolme_istemci_if;
    import bolme_istemci_pkg::*;

    logic [VeriGen-1:0] kars_bolunen;
    logic [VeriGen-1:0] kars_bolen;
    logic               kars_isaret;
    logic               eslesme;
    logic               gecerli;

    logic               doldur;
    logic [VeriGen-1:0] doldur_bolunen;
    logic [VeriGen-1:0] doldur_bolen;
    logic               doldur_isaret;
    logic [VeriGen-1:0] doldur_bolum;
    logic [VeriGen-1:0] doldur_kalan;

    logic [VeriGen-1:0] bolum;
    logic [VeriGen-1:0] kalan;

    modport master (
        output kars_bolunen, kars_bolen, kars_isaret,
        output doldur, doldur_bolunen, doldur_bolen, doldur_isaret,
        output doldur_bolum, doldur_kalan,
        input  eslesme, gecerli, bolum, kalan
    );

    modport slave (
        input  kars_bolunen, kars_bolen, kars_isaret,
        input  doldur, doldur_bolunen, doldur_bolen, doldur_isaret,
        input  doldur_bolum, doldur_kalan,
        output eslesme, gecerli, bolum, kalan
    );

endinterface

// File: rtl/bolme_onbellek.sv
// One-entry operand-match cache for the division client.
// Remembers the last divide's dividend, divisor and signedness together
// with the quotient and remainder the divider produced for it.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-low reset, invalidates the entry
//   oy    : compare/fill/valid bundle (slave side)
module bolme_onbellek
    import bolme_istemci_pkg::*;
(
    input logic         clk_i,
    input logic         rst_i,
    bolme_istemci_if.slave oy
);

    logic               gecerli_q;
    logic [VeriGen-1:0] bolunen_q;
    logic [VeriGen-1:0] bolen_q;
    logic               isaret_q;
    logic [VeriGen-1:0] bolum_q;
    logic [VeriGen-1:0] kalan_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gecerli_q <= 1'b0;
            bolunen_q <= '0;
            bolen_q   <= '0;
            isaret_q  <= 1'b0;
            bolum_q   <= '0;
            kalan_q   <= '0;
        end else if (oy.doldur) begin
            gecerli_q <= 1'b1;
            bolunen_q <= oy.doldur_bolunen;
            bolen_q   <= oy.doldur_bolen;
            isaret_q  <= oy.doldur_isaret;
            bolum_q   <= oy.doldur_bolum;
            kalan_q   <= oy.doldur_kalan;
        end
    end

    // Quotient and remainder come from the same divide, so one entry serves
    // both DIV and REM (or DIVU and REMU) on the same operands.
    assign oy.eslesme = (bolunen_q == oy.kars_bolunen) &&
                        (bolen_q   == oy.kars_bolen)   &&
                        (isaret_q  == oy.kars_isaret);
    assign oy.gecerli = gecerli_q;
    assign oy.bolum   = bolum_q;
    assign oy.kalan   = kalan_q;

endmodule

// File: rtl/bolme_istemci.sv
// Division client: accepts DIV/DIVU/REM/REMU ops from the execute stage,
// answers repeated operand pairs from a one-entry cache, otherwise issues a
// request to an external divider and returns the selected result.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   gecerli_i, islem_i      : op pulse and op code
//   kaynak1_i, kaynak2_i    : dividend, divisor
//   hedef_i / hedef_o       : destination register index in / out
//   temizle_i               : pipeline flush
//   durdur_o                : busy / stall
//   sonuc_o, sonuc_gecerli_o: result and its one-cycle pulse
//   bolme_istek_o, bolme_isaret_o, bolunen_o, bolen_o : divider request side
//   bolum_i, kalan_i, bolme_hazir_i                   : divider response side
module bolme_istemci
    import bolme_istemci_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                gecerli_i,
    input  logic [1:0]          islem_i,
    input  logic [VeriGen-1:0]  kaynak1_i,
    input  logic [VeriGen-1:0]  kaynak2_i,
    input  logic [HedefGen-1:0] hedef_i,
    input  logic                temizle_i,
    output logic                durdur_o,
    output logic [VeriGen-1:0]  sonuc_o,
    output logic                sonuc_gecerli_o,
    output logic [HedefGen-1:0] hedef_o,
    output logic                bolme_istek_o,
    output logic                bolme_isaret_o,
    output logic [VeriGen-1:0]  bolunen_o,
    output logic [VeriGen-1:0]  bolen_o,
    input  logic [VeriGen-1:0]  bolum_i,
    input  logic [VeriGen-1:0]  kalan_i,
    input  logic                bolme_hazir_i
);

    durum_e              durum_q, durum_d;
    logic                iptal_q, iptal_d;
    logic                kalan_sec_q;
    logic [HedefGen-1:0] hedef_q;
    logic                isaret_q;
    logic [VeriGen-1:0]  bolunen_q;
    logic [VeriGen-1:0]  bolen_q;

    logic                kabul;
    logic                yakala;
    logic                isabet;
    logic                son;

    bolme_istemci_if oy_if ();

    bolme_onbellek u_onbellek (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .oy    (oy_if)
    );

    // Compare against the incoming op; fill with the latched operands so the
    // entry describes the divide that actually ran.
    assign oy_if.kars_bolunen   = kaynak1_i;
    assign oy_if.kars_bolen     = kaynak2_i;
    assign oy_if.kars_isaret    = isaretli_islem(islem_i);
    assign oy_if.doldur         = yakala;
    assign oy_if.doldur_bolunen = bolunen_q;
    assign oy_if.doldur_bolen   = bolen_q;
    assign oy_if.doldur_isaret  = isaret_q;
    assign oy_if.doldur_bolum   = bolum_i;
    assign oy_if.doldur_kalan   = kalan_i;

    assign isabet = oy_if.gecerli && oy_if.eslesme;

    always_comb begin
        durum_d = durum_q;
        iptal_d = iptal_q;
        kabul   = 1'b0;
        yakala  = 1'b0;
        unique case (durum_q)
            StBos: begin
                if (gecerli_i && !temizle_i) begin
                    kabul   = 1'b1;
                    iptal_d = 1'b0;
                    durum_d = isabet ? StSon : StIstek;
                end
            end
            StIstek: begin
                if (temizle_i) begin
                    iptal_d = 1'b1;
                    durum_d = StIptal;
                end else begin
                    durum_d = StBekle;
                end
            end
            StBekle: begin
                if (bolme_hazir_i) begin
                    // A flush arriving with the result still fills the cache.
                    yakala  = 1'b1;
                    durum_d = StSon;
                    if (temizle_i) begin
                        iptal_d = 1'b1;
                    end
                end else if (temizle_i) begin
                    iptal_d = 1'b1;
                    durum_d = StIptal;
                end
            end
            StIptal: begin
                // The divider cannot be aborted; drain it and keep the result.
                if (bolme_hazir_i) begin
                    yakala  = 1'b1;
                    durum_d = StSon;
                end
            end
            StSon: begin
                durum_d = StBos;
            end
            default: begin
                durum_d = StBos;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q     <= StBos;
            iptal_q     <= 1'b0;
            kalan_sec_q <= 1'b0;
            hedef_q     <= '0;
            isaret_q    <= 1'b0;
            bolunen_q   <= '0;
            bolen_q     <= '0;
        end else begin
            durum_q <= durum_d;
            iptal_q <= iptal_d;
            if (kabul) begin
                kalan_sec_q <= kalan_islemi(islem_i);
                hedef_q     <= hedef_i;
                isaret_q    <= isaretli_islem(islem_i);
                bolunen_q   <= kaynak1_i;
                bolen_q     <= kaynak2_i;
            end
        end
    end

    assign son             = (durum_q == StSon);
    assign durdur_o        = (durum_q != StBos);
    assign bolme_istek_o   = (durum_q == StIstek);
    assign sonuc_gecerli_o = son && !iptal_q;
    assign sonuc_o         = son ? (kalan_sec_q ? oy_if.kalan : oy_if.bolum) : '0;
    assign hedef_o         = son ? hedef_q : '0;
    assign bolme_isaret_o  = isaret_q;
    assign bolunen_o       = bolunen_q;
    assign bolen_o         = bolen_q;

endmodule

// File: tb/tb_bolme_istemci.sv
// Self-checking bench for bolme_istemci: a behavioural divider with
// programmable latency, directed corner cases, then randomized ops.
// Expected results go into a scoreboard queue; a monitor pops on each
// result pulse.
module tb_bolme_istemci;
    import bolme_istemci_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        gecerli_i = 1'b0;
    logic [1:0]  islem_i = 2'b00;
    logic [31:0] kaynak1_i = '0;
    logic [31:0] kaynak2_i = '0;
    logic [4:0]  hedef_i = '0;
    logic        temizle_i = 1'b0;
    logic        durdur_o;
    logic [31:0] sonuc_o;
    logic        sonuc_gecerli_o;
    logic [4:0]  hedef_o;
    logic        bolme_istek_o;
    logic        bolme_isaret_o;
    logic [31:0] bolunen_o;
    logic [31:0] bolen_o;
    logic [31:0] bolum_i = '0;
    logic [31:0] kalan_i = '0;
    logic        bolme_hazir_i = 1'b0;

    always #5 clk = ~clk;

    bolme_istemci dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .gecerli_i       (gecerli_i),
        .islem_i         (islem_i),
        .kaynak1_i       (kaynak1_i),
        .kaynak2_i       (kaynak2_i),
        .hedef_i         (hedef_i),
        .temizle_i       (temizle_i),
        .durdur_o        (durdur_o),
        .sonuc_o         (sonuc_o),
        .sonuc_gecerli_o (sonuc_gecerli_o),
        .hedef_o         (hedef_o),
        .bolme_istek_o   (bolme_istek_o),
        .bolme_isaret_o  (bolme_isaret_o),
        .bolunen_o       (bolunen_o),
        .bolen_o         (bolen_o),
        .bolum_i         (bolum_i),
        .kalan_i         (kalan_i),
        .bolme_hazir_i   (bolme_hazir_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] sonuc;
        logic [4:0]  hedef;
    } beklenen_t;
    beklenen_t sb_q[$];

    // Reference cache contents: last divide that actually ran.
    logic        m_gecerli = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_s = 1'b0;

    // RISC-V M-extension division semantics.
    function automatic logic [31:0] rv_bol(input logic [31:0] a, input logic [31:0] b,
                                           input logic isaretli, input logic kalan);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return kalan ? a : 32'hFFFF_FFFF;
        if (isaretli) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return kalan ? 32'd0 : 32'h8000_0000;
            if (kalan) return sa % sb;
            return sa / sb;
        end
        if (kalan) return a % b;
        return a / b;
    endfunction

    task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_tests++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", ad, gercek, beklenen);
        end
    endtask

    // Behavioural divider: result pulse bol_gecikme cycles after it sees a request.
    int          bol_gecikme = 3;
    bit          bol_mesgul = 1'b0;
    int          bol_sayac = 0;
    logic [31:0] bol_a, bol_b;
    logic        bol_s;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bolme_hazir_i = 1'b0;
            bolum_i = $urandom;
            kalan_i = $urandom;
            if (bol_mesgul) begin
                bol_sayac--;
                if (bol_sayac == 0) begin
                    bolme_hazir_i = 1'b1;
                    bolum_i = rv_bol(bol_a, bol_b, bol_s, 1'b0);
                    kalan_i = rv_bol(bol_a, bol_b, bol_s, 1'b1);
                    bol_mesgul = 1'b0;
                end
            end else if (bolme_istek_o) begin
                bol_mesgul = 1'b1;
                bol_sayac = bol_gecikme;
                bol_a = bolunen_o;
                bol_b = bolen_o;
                bol_s = bolme_isaret_o;
            end
        end
    end

    // Monitor: every result pulse must match the oldest expected entry.
    initial begin
        beklenen_t e;
        forever begin
            @(negedge clk);
            if (sonuc_gecerli_o) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got sonuc %h hedef %0d, required no pulse",
                             sonuc_o, hedef_o);
                end else begin
                    e = sb_q.pop_front();
                    check("sonuc", sonuc_o, e.sonuc);
                    check("hedef", 32'(hedef_o), 32'(e.hedef));
                end
            end
        end
    end

    task automatic bosta_bekle();
        int n;
        n = 0;
        while (durdur_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (durdur_o) check("idle_timeout", 32'(durdur_o), 32'd0);
    endtask

    // Issue one op. gecikme: divider latency; temizle_k: cycle after acceptance
    // (1 = first cycle after) where temizle_i is pulsed, 0 for none.
    task automatic islem_yap(input logic [1:0] islem, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] hedef, input int gecikme, input int temizle_k);
        logic      isaretli, kalan, isabet, iptal;
        int        istek_sayisi, istek_k, sonuc_k, bitis_k;
        beklenen_t e;
        bosta_bekle();
        isaretli = (islem == IslemDiv) || (islem == IslemRem);
        kalan    = (islem == IslemRem) || (islem == IslemRemu);
        isabet   = m_gecerli && (m_a == a) && (m_b == b) && (m_s == isaretli);
        // A miss is flushed if temizle lands anywhere from the request cycle
        // through the divider's ready cycle (H = 1 + gecikme).
        iptal    = !isabet && (temizle_k >= 1) && (temizle_k <= gecikme + 1);
        if (!iptal) begin
            e.sonuc = rv_bol(a, b, isaretli, kalan);
            e.hedef = hedef;
            sb_q.push_back(e);
        end
        if (!isabet) begin
            m_gecerli = 1'b1;
            m_a = a;
            m_b = b;
            m_s = isaretli;
        end
        bol_gecikme = gecikme;

        gecerli_i = 1'b1;
        islem_i   = islem;
        kaynak1_i = a;
        kaynak2_i = b;
        hedef_i   = hedef;
        temizle_i = 1'b0;
        @(posedge clk);
        #1;
        // Scramble inputs so any use of unlatched values shows up.
        gecerli_i = 1'b0;
        islem_i   = 2'($urandom_range(0, 3));
        kaynak1_i = $urandom;
        kaynak2_i = $urandom;
        hedef_i   = 5'($urandom);

        istek_sayisi = 0;
        istek_k = 0;
        sonuc_k = 0;
        bitis_k = 0;
        for (int k = 1; k <= gecikme + 10; k++) begin
            temizle_i = (k == temizle_k);
            if (bolme_istek_o) begin
                istek_sayisi++;
                istek_k = k;
                check("bolme_isaret", 32'(bolme_isaret_o), 32'(isaretli));
                check("bolunen", bolunen_o, a);
                check("bolen", bolen_o, b);
            end
            if (sonuc_gecerli_o) sonuc_k = k;
            if (!durdur_o) begin
                bitis_k = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        temizle_i = 1'b0;

        check("istek_count", 32'(istek_sayisi), isabet ? 32'd0 : 32'd1);
        if (!isabet) check("istek_cycle", 32'(istek_k), 32'd1);
        check("result_cycle", 32'(sonuc_k),
              iptal ? 32'd0 : (isabet ? 32'd1 : 32'(gecikme + 2)));
        check("busy_end", 32'(bitis_k), isabet ? 32'd2 : 32'(gecikme + 3));
    endtask

    task automatic cikislar_sifir(input string ad);
        check({ad, "_durdur"}, 32'(durdur_o), 32'd0);
        check({ad, "_istek"}, 32'(bolme_istek_o), 32'd0);
        check({ad, "_isaret"}, 32'(bolme_isaret_o), 32'd0);
        check({ad, "_bolunen"}, bolunen_o, 32'd0);
        check({ad, "_bolen"}, bolen_o, 32'd0);
        check({ad, "_sonuc"}, sonuc_o, 32'd0);
        check({ad, "_sonuc_gecerli"}, 32'(sonuc_gecerli_o), 32'd0);
        check({ad, "_hedef"}, 32'(hedef_o), 32'd0);
    endtask

    initial begin
        logic [1:0]  r_islem;
        logic [31:0] r_a, r_b;
        int          r_lat, r_tk, n;

        #12;
        cikislar_sifir("reset");
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        islem_yap(IslemDiv, 32'd100, 32'd7, 5'd5, 3, 0);
        islem_yap(IslemRem, 32'hFFFF_FFF9, 32'd2, 5'd7, 4, 0);
        islem_yap(IslemDiv, 32'hFFFF_FFF9, 32'd2, 5'd8, 4, 0);
        islem_yap(IslemDivu, 32'h1234_5678, 32'd0, 5'd9, 2, 0);
        islem_yap(IslemRemu, 32'h1234_5678, 32'd0, 5'd10, 2, 0);
        islem_yap(IslemDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 0);
        islem_yap(IslemRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 0);
        islem_yap(IslemDivu, 32'd1000, 32'd3, 5'd13, 5, 3);
        islem_yap(IslemRemu, 32'd1000, 32'd3, 5'd14, 5, 0);
        // Same operands, other signedness: must miss.
        islem_yap(IslemDiv, 32'd1000, 32'd3, 5'd15, 2, 0);
        // Flush coinciding with ready, flush in SON, flush in request cycle.
        islem_yap(IslemDivu, 32'd77, 32'd5, 5'd16, 3, 4);
        islem_yap(IslemDivu, 32'd78, 32'd5, 5'd17, 3, 5);
        islem_yap(IslemRemu, 32'd79, 32'd5, 5'd18, 3, 1);
        // Flush during a hit's result cycle is ignored.
        islem_yap(IslemDivu, 32'd79, 32'd5, 5'd19, 3, 1);

        // Reset while waiting on the divider.
        bosta_bekle();
        bol_gecikme = 6;
        gecerli_i = 1'b1;
        islem_i   = IslemDiv;
        kaynak1_i = 32'd55;
        kaynak2_i = 32'd5;
        hedef_i   = 5'd3;
        @(posedge clk);
        #1;
        gecerli_i = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(durdur_o), 32'd1);
        rst_i = 1'b0;
        #1;
        cikislar_sifir("midop_reset");
        m_gecerli = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        n = 0;
        while (bol_mesgul && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("divider_drained", 32'(bol_mesgul), 32'd0);
        @(posedge clk);
        #1;
        check("post_reset_idle", 32'(durdur_o), 32'd0);
        islem_yap(IslemDiv, 32'd55, 32'd5, 5'd3, 2, 0);

        // Randomized ops, reusing operands often to exercise the cache.
        for (int i = 0; i < 150; i++) begin
            r_islem = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                r_a = m_a;
                r_b = m_b;
            end else begin
                r_a = $urandom;
                case ($urandom_range(0, 5))
                    0: r_b = 32'd0;
                    1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                    2: r_b = 32'($urandom_range(1, 9));
                    default: r_b = $urandom;
                endcase
            end
            r_lat = $urandom_range(1, 5);
            r_tk  = ($urandom_range(0, 9) < 3) ? $urandom_range(1, r_lat + 2) : 0;
            islem_yap(r_islem, r_a, r_b, 5'($urandom), r_lat, r_tk);
        end

        bosta_bekle();
        @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
